// File: rtl/btn_evt_pkg.sv
// Shared types for the button event decoder and its consumers: FSM state and the
// bundled one-cycle event pulses.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StHeld
  } btn_state_t;

  typedef struct packed {
    logic press;
    logic short_release;
    logic long_press;
    logic auto_repeat;
    logic any_release;
  } btn_evt_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into press/short/long/repeat/release pulses.
// Auto-repeat while held is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic btn_in,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic long_held
);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("btn_event_decoder: LONG_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned CntW = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);
`else
  localparam int unsigned CntW = $clog2(LONG_CYCLES);
`endif
  localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);

  btn_state_t      state_q = StIdle;
  btn_state_t      state_d;
  logic [CntW-1:0] cnt_q = '0;
  logic [CntW-1:0] cnt_d;
  btn_evt_t        evt_q = '0;
  btn_evt_t        evt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = '0;
    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (btn_in) begin
            evt_d.press = 1'b1;
            cnt_d       = '0;
            state_d     = StPressed;
          end
        end
        StPressed: begin
          if (!btn_in) begin
            evt_d.short_release = 1'b1;
            evt_d.any_release   = 1'b1;
            state_d             = StIdle;
          end else if (cnt_q == LongLast) begin
            evt_d.long_press = 1'b1;
            cnt_d            = '0;
            state_d          = StHeld;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StHeld: begin
          if (!btn_in) begin
            evt_d.any_release = 1'b1;
            state_d           = StIdle;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (cnt_q == RepLast) begin
            evt_d.auto_repeat = 1'b1;
            cnt_d             = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  // Without auto-repeat the auto_repeat bit is never set, so repeat_pulse stays 0.
  assign press_pulse   = evt_q.press;
  assign short_pulse   = evt_q.short_release;
  assign long_pulse    = evt_q.long_press;
  assign repeat_pulse  = evt_q.auto_repeat;
  assign release_pulse = evt_q.any_release;
  assign long_held     = (state_q == StHeld);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder: directed scenarios plus randomized
// stimulus against a hold-duration reference model.
module tb_btn_event_decoder;

  localparam int unsigned LongC = 4;
  localparam int unsigned RepC  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic btn_in = 1'b0;
  logic press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, long_held;

  btn_event_decoder #(
    .LONG_CYCLES  (LongC),
    .REPEAT_CYCLES(RepC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse),
    .long_held    (long_held)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: whether the button is considered down and how many enabled samples it has
  // been held since the press sample.
  bit         m_down = 1'b0;
  int         m_hold = 0;
  logic [5:0] exp_v  = '0;
  logic [5:0] obs_v;
  assign obs_v = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, long_held};

  task automatic drive(input logic r, input logic e, input logic b);
    logic p, s, l, rp, rl;
    @(negedge clk);
    rst = r; ena = e; btn_in = b;
    @(posedge clk);
    {p, s, l, rp, rl} = '0;
    if (r) begin
      m_down = 1'b0;
      m_hold = 0;
    end else if (e) begin
      if (b) begin
        if (!m_down) begin
          p = 1'b1; m_down = 1'b1; m_hold = 0;
        end else begin
          m_hold++;
          if (m_hold == LongC) l = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          else if (m_hold > LongC && ((m_hold - LongC) % RepC) == 0) rp = 1'b1;
`endif
        end
      end else if (m_down) begin
        rl = 1'b1;
        s = (m_hold < LongC);
        m_down = 1'b0;
      end
    end
    exp_v = {p, s, l, rp, rl, (m_down && m_hold >= LongC)};
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b1);
      n_total++;
      if (obs_v !== 6'b0) $display("FAIL reset cyc %0d: got %b want %b", c, obs_v, 6'b0);
      else n_pass++;
    end
  endtask

  task automatic test_short_press();
    int press_at = -1, rel_at = -1, short_at = -1, longs = 0;
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b1, c < 2);
      n_total++;
      if (obs_v !== exp_v) $display("FAIL short_model cyc %0d: got %b want %b", c + 1, obs_v, exp_v);
      else n_pass++;
      if (press_pulse && press_at < 0) press_at = c + 1;
      if (release_pulse && rel_at < 0) rel_at = c + 1;
      if (short_pulse && short_at < 0) short_at = c + 1;
      if (long_pulse) longs++;
    end
    n_total++;
    if (press_at != 1 || rel_at != 3 || short_at != 3 || longs != 0)
      $display("FAIL short_timing: got press %0d rel %0d short %0d longs %0d want 1 3 3 0",
               press_at, rel_at, short_at, longs);
    else n_pass++;
  endtask

  task automatic test_long_hold();
    int press_at = -1, long_at = -1, held_from = -1, rel_at = -1, shorts = 0;
    logic [31:0] rep_mask = '0, want_mask;
`ifdef BTN_AUTO_REPEAT_EN
    want_mask = (32'd1 << 8) | (32'd1 << 11);
`else
    want_mask = '0;
`endif
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, 1'b1, c < 12);
      n_total++;
      if (obs_v !== exp_v) $display("FAIL long_model cyc %0d: got %b want %b", c + 1, obs_v, exp_v);
      else n_pass++;
      if (press_pulse && press_at < 0) press_at = c + 1;
      if (long_pulse && long_at < 0) long_at = c + 1;
      if (long_held && held_from < 0) held_from = c + 1;
      if (release_pulse && rel_at < 0) rel_at = c + 1;
      if (repeat_pulse) rep_mask[c + 1] = 1'b1;
      if (short_pulse) shorts++;
    end
    n_total++;
    if (press_at != 1 || long_at != 5 || held_from != 5 || rel_at != 13 || shorts != 0)
      $display("FAIL long_timing: got press %0d long %0d held %0d rel %0d shorts %0d want 1 5 5 13 0",
               press_at, long_at, held_from, rel_at, shorts);
    else n_pass++;
    n_total++;
    if (rep_mask !== want_mask) $display("FAIL repeat_cycles: got %h want %h", rep_mask, want_mask);
    else n_pass++;
  endtask

  task automatic test_sparse_ena();
    int press_at = -1, long_at = -1, overlaps = 0;
    logic [4:0] prev = '0;
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 24; c++) begin
      drive(1'b0, (c % 4) == 0, 1'b1);
      n_total++;
      if (obs_v !== exp_v) $display("FAIL sparse_model cyc %0d: got %b want %b", c + 1, obs_v, exp_v);
      else n_pass++;
      if (press_pulse && press_at < 0) press_at = c + 1;
      if (long_pulse && long_at < 0) long_at = c + 1;
      if ((obs_v[5:1] & prev) != 0) overlaps++;
      prev = obs_v[5:1];
    end
    n_total++;
    if (press_at != 1 || long_at != 17 || overlaps != 0)
      $display("FAIL sparse_timing: got press %0d long %0d wide %0d want 1 17 0",
               press_at, long_at, overlaps);
    else n_pass++;
  endtask

  task automatic test_reset_mid_press();
    int early_rel = 0, second_press = -1;
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 14; c++) begin
      drive(c == 7, 1'b1, c < 12);
      n_total++;
      if (obs_v !== exp_v) $display("FAIL rstmid_model cyc %0d: got %b want %b", c + 1, obs_v, exp_v);
      else n_pass++;
      if (c + 1 == 8) begin
        n_total++;
        if (obs_v !== 6'b0) $display("FAIL rstmid_clear: got %b want %b", obs_v, 6'b0);
        else n_pass++;
      end
      if (release_pulse && c + 1 <= 12) early_rel++;
      if (press_pulse && c + 1 > 1 && second_press < 0) second_press = c + 1;
    end
    n_total++;
    if (early_rel != 0 || second_press != 9)
      $display("FAIL rstmid_timing: got rel %0d repress %0d want 0 9", early_rel, second_press);
    else n_pass++;
  endtask

  task automatic test_threshold_release();
    int rel_at = -1, short_at = -1, longs = 0;
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b1, c < 4);
      n_total++;
      if (obs_v !== exp_v) $display("FAIL edge_model cyc %0d: got %b want %b", c + 1, obs_v, exp_v);
      else n_pass++;
      if (release_pulse && rel_at < 0) rel_at = c + 1;
      if (short_pulse && short_at < 0) short_at = c + 1;
      if (long_pulse) longs++;
    end
    n_total++;
    if (rel_at != 5 || short_at != 5 || longs != 0)
      $display("FAIL edge_timing: got rel %0d short %0d longs %0d want 5 5 0",
               rel_at, short_at, longs);
    else n_pass++;
  endtask

  task automatic test_random();
    logic b = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) b = ~b;
      drive($urandom_range(60) == 0, $urandom_range(3) != 0, b);
      n_total++;
      if (obs_v !== exp_v) $display("FAIL random cyc %0d: got %b want %b", c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_hold();
    test_sparse_ena();
    test_reset_mid_press();
    test_threshold_release();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/btn_event_decoder.md
# btn_event_decoder

Consumes a clean, debounced button level and classifies each press into single-cycle event pulses: press, short release, long press and auto-repeat. One instance sits downstream of each button's debouncer. It feeds the timer/stopwatch control FSM, which needs edge-style commands rather than raw levels.

## Interface
- `LONG_CYCLES`, default 1000: enabled high samples after the press sample before `long_pulse` fires; must be ≥ 2.
- `REPEAT_CYCLES`, default 250: enabled high samples between successive `repeat_pulse` events while held; must be ≥ 1.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  sample-rate tick; state advances only on cycles where it is 1.
- `btn_in`  in  1  debounced button level; 1 = pressed.
- `press_pulse`  out  1  one-clk pulse on press detection.
- `short_pulse`  out  1  one-clk pulse on release before the long threshold.
- `long_pulse`  out  1  one-clk pulse when the long threshold is reached.
- `repeat_pulse`  out  1  one-clk pulse on each auto-repeat interval.
- `release_pulse`  out  1  one-clk pulse on any release.
- `long_held`  out  1  level; 1 while in HELD.

## Operation
- FSM states: IDLE, PRESSED, HELD. Single counter `cnt`, width `$clog2(max(LONG_CYCLES, REPEAT_CYCLES))`.
- Transitions are evaluated only on cycles where `ena` = 1. On cycles where `ena` = 0:
  - state and `cnt` hold;
  - all pulse outputs are 0.
- IDLE, `btn_in` = 1:
  - go to PRESSED, set `cnt` = 0;
  - assert `press_pulse`.
- IDLE, `btn_in` = 0: no action.
- PRESSED, `btn_in` = 0:
  - assert `short_pulse` and `release_pulse` together;
  - go to IDLE.
- PRESSED, `btn_in` = 1, `cnt` == LONG_CYCLES-1:
  - assert `long_pulse`;
  - set `cnt` = 0, go to HELD.
- PRESSED, `btn_in` = 1, otherwise: `cnt` + 1.
- HELD, `btn_in` = 0:
  - assert `release_pulse` only;
  - go to IDLE.
- HELD, `btn_in` = 1, `cnt` == REPEAT_CYCLES-1:
  - assert `repeat_pulse`;
  - set `cnt` = 0.
- HELD, `btn_in` = 1, otherwise: `cnt` + 1.
- The counter never wraps past its compare value. Counting is in enabled samples, not clk cycles.
- `long_held` = (state == HELD).

## Timing
- All outputs are registered. A pulse appears in the clk cycle after the enabled sample that caused it and is exactly one clk wide.
- Latency from the press sample (sample 0):
  - `press_pulse` follows sample 0;
  - `long_pulse` follows enabled sample LONG_CYCLES;
  - the first `repeat_pulse` follows sample LONG_CYCLES+REPEAT_CYCLES;
  - later repeats are every REPEAT_CYCLES samples.
- Simultaneous events: at most one FSM transition per sample. `short_pulse` and `release_pulse` coincide by design; no other pulses coincide.
- Reset: `rst` = 1 on any clk edge has priority over `ena`. It forces:
  - state IDLE;
  - `cnt` = 0;
  - all outputs 0.
- Reset mid-press produces no `release_pulse`. If `btn_in` is still 1 at the first enabled sample after reset, it is treated as a new press.
- Power-up initial values equal the reset values.

## Configuration
- Macro `BTN_AUTO_REPEAT_EN`.
- Defined: HELD counts and emits `repeat_pulse` as above.
- Undefined:
  - HELD does not count;
  - `repeat_pulse` is tied to 0;
  - `REPEAT_CYCLES` is ignored;
  - counter width is `$clog2(LONG_CYCLES)`.

## Structure
- Shared package `btn_evt_pkg` holds:
  - the state typedef `btn_state_t` (IDLE, PRESSED, HELD);
  - the struct `btn_evt_t` bundling the five pulses, for the control FSM's port lists.
- No sub-module is needed; the FSM and counter live in one `always_ff` with a small next-state `always_comb`.

## Test plan
All scenarios use LONG_CYCLES=4, REPEAT_CYCLES=3 and `ena` = 1 every cycle unless stated.
1. Short press: `btn_in` high for cycles 0–1, low at cycle 2.
   - `press_pulse` at cycle 1;
   - `short_pulse` and `release_pulse` at cycle 3;
   - no `long_pulse`.
2. Long hold with the macro defined: `btn_in` high for cycles 0–11, low at cycle 12.
   - `press_pulse` at 1;
   - `long_pulse` at 5 and `long_held` = 1 from 5;
   - `repeat_pulse` at 8 and 11;
   - `release_pulse` at 13 with no `short_pulse`.
3. Same stimulus as scenario 2 with the macro undefined: `long_pulse` at 5, `repeat_pulse` never asserts, `release_pulse` at 13.
4. `ena` every 4th cycle (0, 4, 8, …) with `btn_in` held high:
   - `press_pulse` at 1;
   - `long_pulse` at 17;
   - every pulse is one clk wide.
5. `rst` asserted at cycle 7 of scenario 2 and released at cycle 8, `btn_in` still high:
   - all outputs 0 at cycle 8;
   - no `release_pulse`;
   - new `press_pulse` at cycle 9.
6. `btn_in` falls on the same sample that would reach the long threshold (high 0–3, low at 4):
   - `short_pulse` and `release_pulse` at 5;
   - no `long_pulse`.
